// File: rtl/gsram_result_reader_pkg.sv
// Shared constants and types for the gSRAM result reader.
package gsram_result_reader_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;

   typedef logic signed [DATA_W-1:0] q8_8_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } rd_state_t;

endpackage

// File: rtl/gsram_result_reader_if.sv
// Result stream bundle: one Q8.8 word plus its row/col tag.
interface gsram_result_reader_if;
   import gsram_result_reader_pkg::*;

   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_row;
   logic [ADDR_W-1:0] out_col;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data, out_row, out_col, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_row, out_col, out_last, out_valid,
      output out_ready
   );

endinterface

// File: rtl/gsram_result_reader_fifo2.sv
// Two-entry FIFO with occupancy count; push and pop may coincide.
module result_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/gsram_result_reader.sv
// Row-major gSRAM drain onto a valid/ready stream.
// Optional per-row argmax: define GSRAM_ARGMAX_EN.
module gsram_result_reader
   import gsram_result_reader_pkg::*;
#(
   parameter int NUM_ROWS = 10,
   parameter int NUM_COLS = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     rd_row,
   output logic [ADDR_W-1:0]     rd_col,
   output logic                  rd_en,
   input  logic [DATA_W-1:0]     rdata,
   gsram_result_reader_if.master res,
   output logic                  amax_valid,
   output logic [ADDR_W-1:0]     amax_row,
   output logic [ADDR_W-1:0]     amax_idx
);

   localparam int EW = DATA_W + 2 * ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLS - 1);

   rd_state_t         st;
   rd_state_t         st_nx;
   logic              inflight;
   logic [ADDR_W-1:0] tag_row;
   logic [ADDR_W-1:0] tag_col;
   logic              push;
   logic              pop;
   logic [1:0]        count;
   logic [EW-1:0]     head;
   logic [2:0]        used;
   logic              last_addr;

   assign push      = inflight;
   assign pop       = res.out_valid & res.out_ready;
   assign last_addr = (rd_row == LAST_ROW) && (rd_col == LAST_COL);

   // A word leaving this cycle frees its slot, so back-to-back reads keep flowing.
   assign used = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};

   always_comb begin
      st_nx = st;
      rd_en = 1'b0;
      unique case (st)
         S_IDLE: begin
            if (start) st_nx = S_READ;
         end
         S_READ: begin
            rd_en = (used < 3'd2);
            if (rd_en && last_addr) st_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && res.out_last) st_nx = S_DONE;
         end
         S_DONE: begin
            st_nx = S_IDLE;
         end
         default: st_nx = S_IDLE;
      endcase
   end

   assign busy = (st != S_IDLE);
   assign done = (st == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= S_IDLE;
         rd_row   <= '0;
         rd_col   <= '0;
         inflight <= 1'b0;
         tag_row  <= '0;
         tag_col  <= '0;
      end else begin
         st       <= st_nx;
         inflight <= rd_en;
         if (rd_en) begin
            tag_row <= rd_row;
            tag_col <= rd_col;
            if (last_addr) begin
               rd_row <= '0;
               rd_col <= '0;
            end else if (rd_col == LAST_COL) begin
               rd_col <= '0;
               rd_row <= rd_row + 1'b1;
            end else begin
               rd_col <= rd_col + 1'b1;
            end
         end
      end
   end

   result_fifo2 #(
      .W(EW)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data({rdata, tag_row, tag_col}),
      .pop      (pop),
      .pop_data (head),
      .count    (count)
   );

   assign res.out_valid = (count != 2'd0);
   assign res.out_data  = head[EW-1 -: DATA_W];
   assign res.out_row   = head[2*ADDR_W-1 -: ADDR_W];
   assign res.out_col   = head[ADDR_W-1:0];
   assign res.out_last  = res.out_valid
                        && (res.out_row == LAST_ROW)
                        && (res.out_col == LAST_COL);

`ifdef GSRAM_ARGMAX_EN
   q8_8_t             pdata;
   q8_8_t             run_max;
   q8_8_t             max_nx;
   logic [ADDR_W-1:0] run_idx;
   logic [ADDR_W-1:0] idx_nx;

   assign pdata = rdata;

   // Strict compare so ties keep the lowest column.
   always_comb begin
      max_nx = run_max;
      idx_nx = run_idx;
      if (tag_col == '0) begin
         max_nx = pdata;
         idx_nx = '0;
      end else if (pdata > run_max) begin
         max_nx = pdata;
         idx_nx = tag_col;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_max    <= '0;
         run_idx    <= '0;
         amax_valid <= 1'b0;
         amax_row   <= '0;
         amax_idx   <= '0;
      end else begin
         amax_valid <= push && (tag_col == LAST_COL);
         if (push) begin
            run_max <= max_nx;
            run_idx <= idx_nx;
            if (tag_col == LAST_COL) begin
               amax_row <= tag_row;
               amax_idx <= idx_nx;
            end
         end
      end
   end
`else
   assign amax_valid = 1'b0;
   assign amax_row   = '0;
   assign amax_idx   = '0;
`endif

endmodule

// File: tb/tb_gsram_result_reader.sv
// Randomized self-checking bench: 2x3 reader (a) and 1x1 reader (b).
module tb_gsram_result_reader;
   import gsram_result_reader_pkg::*;

   localparam int NR = 2;
   localparam int NC = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              start_a, busy_a, done_a, rd_en_a;
   logic [ADDR_W-1:0] rd_row_a, rd_col_a;
   logic [DATA_W-1:0] rdata_a;
   logic              amax_valid_a;
   logic [ADDR_W-1:0] amax_row_a, amax_idx_a;

   logic              start_b, busy_b, done_b, rd_en_b;
   logic [ADDR_W-1:0] rd_row_b, rd_col_b;
   logic [DATA_W-1:0] rdata_b;
   logic              amax_valid_b;
   logic [ADDR_W-1:0] amax_row_b, amax_idx_b;

   gsram_result_reader_if res_a ();
   gsram_result_reader_if res_b ();

   gsram_result_reader #(.NUM_ROWS(NR), .NUM_COLS(NC)) u_a (
      .clk(clk), .reset(reset), .start(start_a),
      .busy(busy_a), .done(done_a),
      .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_en(rd_en_a),
      .rdata(rdata_a), .res(res_a),
      .amax_valid(amax_valid_a), .amax_row(amax_row_a),
      .amax_idx(amax_idx_a)
   );

   gsram_result_reader #(.NUM_ROWS(1), .NUM_COLS(1)) u_b (
      .clk(clk), .reset(reset), .start(start_b),
      .busy(busy_b), .done(done_b),
      .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_en(rd_en_b),
      .rdata(rdata_b), .res(res_b),
      .amax_valid(amax_valid_b), .amax_row(amax_row_b),
      .amax_idx(amax_idx_b)
   );

   logic [DATA_W-1:0] mem_a [16][16];
   logic [DATA_W-1:0] mem_b [16][16];

   always @(posedge clk) begin
      if (rd_en_a) rdata_a <= mem_a[rd_row_a][rd_col_a];
      if (rd_en_b) rdata_b <= mem_b[rd_row_b][rd_col_b];
   end

   int checks = 0;
   int errors = 0;
   int n_amax;
   int am_idx [16];

   function automatic logic rdy(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int ref_argmax(input int r);
      int best = 0;
      for (int c = 1; c < NC; c++)
         if ($signed(mem_a[r][c]) > $signed(mem_a[r][best])) best = c;
      return best;
   endfunction

   task automatic fill_pattern();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            mem_a[r][c] = DATA_W'(16 * r + c);
   endtask

   task automatic fill_random();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            mem_a[r][c] = DATA_W'($urandom);
   endtask

   task automatic run_a(input int mode, input bit restart,
                        output int nw, output int nd,
                        output int fv, output int frd,
                        output int last_c, output int done_c);
      int issued = 0;
      int accepted = 0;
      logic held = 1'b0;
      logic [DATA_W-1:0] h_data;
      logic [ADDR_W-1:0] h_row, h_col;
      logic hs;
      int r, c;
      nw = 0; nd = 0; fv = -1; frd = -1; last_c = -1; done_c = -1;
      n_amax = 0;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         start_a = restart && (cyc == 3);
         res_a.out_ready = rdy(mode, cyc);
         #1;
         hs = res_a.out_valid & res_a.out_ready;
         if (rd_en_a) begin
            issued++;
            if (frd < 0) frd = cyc;
         end
         if (hs) accepted++;
         checks++;
         if (issued - accepted > 2) begin
            errors++;
            $display("FAIL credit cyc=%0d outstanding=%0d max=2", cyc, issued - accepted);
         end
         if (held) begin
            checks++;
            if (res_a.out_valid !== 1'b1 || res_a.out_data !== h_data ||
                res_a.out_row !== h_row || res_a.out_col !== h_col) begin
               errors++;
               $display("FAIL hold cyc=%0d got v=%b d=%h expected v=1 d=%h",
                        cyc, res_a.out_valid, res_a.out_data, h_data);
            end
         end
         held   = res_a.out_valid & ~res_a.out_ready;
         h_data = res_a.out_data;
         h_row  = res_a.out_row;
         h_col  = res_a.out_col;
         if (res_a.out_valid && fv < 0) fv = cyc;
         if (hs) begin
            r = nw / NC;
            c = nw % NC;
            checks++;
            if (nw >= NR * NC) begin
               errors++;
               $display("FAIL extra_word cyc=%0d got word %0d expected at most %0d", cyc, nw + 1, NR * NC);
            end else if (res_a.out_data !== mem_a[r][c] ||
                res_a.out_row !== ADDR_W'(r) || res_a.out_col !== ADDR_W'(c) ||
                res_a.out_last !== (nw == NR * NC - 1)) begin
               errors++;
               $display("FAIL word%0d got d=%h r=%0d c=%0d l=%b expected d=%h r=%0d c=%0d l=%b",
                        nw, res_a.out_data, res_a.out_row, res_a.out_col, res_a.out_last,
                        mem_a[r][c], r, c, (nw == NR * NC - 1));
            end
            nw++;
            last_c = cyc;
         end
         if (done_a) begin
            nd++;
            if (done_c < 0) done_c = cyc;
         end
`ifdef GSRAM_ARGMAX_EN
         if (amax_valid_a) begin
            checks++;
            if (n_amax >= NR || amax_row_a !== ADDR_W'(n_amax) ||
                amax_idx_a !== ADDR_W'(ref_argmax(n_amax % NR))) begin
               errors++;
               $display("FAIL amax n=%0d got row=%0d idx=%0d expected row=%0d idx=%0d",
                        n_amax, amax_row_a, amax_idx_a, n_amax, ref_argmax(n_amax % NR));
            end
            am_idx[n_amax % 16] = int'(amax_idx_a);
            n_amax++;
         end
`else
         checks++;
         if (amax_valid_a !== 1'b0 || amax_row_a !== '0 || amax_idx_a !== '0) begin
            errors++;
            $display("FAIL amax_tied got v=%b r=%0d i=%0d expected 0", amax_valid_a, amax_row_a, amax_idx_a);
         end
`endif
         if (done_c >= 0 && cyc >= done_c + 3) break;
      end
      start_a = 1'b0;
      if (done_c < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout got no done expected done");
      end
   endtask

   task automatic check_count(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      res_a.out_ready = 1'b0;
      res_b.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy_a, done_a, rd_en_a, rd_row_a, rd_col_a, res_a.out_valid, res_a.out_last,
           res_a.out_data, res_a.out_row, res_a.out_col, amax_valid_a, amax_row_a, amax_idx_a} !== '0) begin
         errors++;
         $display("FAIL reset_a got busy=%b done=%b rd_en=%b v=%b d=%h expected all 0",
                  busy_a, done_a, rd_en_a, res_a.out_valid, res_a.out_data);
      end
      checks++;
      if ({busy_b, done_b, rd_en_b, res_b.out_valid, res_b.out_last, res_b.out_data} !== '0) begin
         errors++;
         $display("FAIL reset_b got busy=%b done=%b v=%b expected 0", busy_b, done_b, res_b.out_valid);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      int nw, nd, fv, frd, lc, dc;
      fill_pattern();
      run_a(0, 1'b0, nw, nd, fv, frd, lc, dc);
      check_count("stream_words", nw, 6);
      check_count("stream_done", nd, 1);
      check_count("stream_first_rd", frd, 0);
      check_count("stream_first_valid", fv, 2);
      check_count("stream_last_cycle", lc, 7);
      check_count("stream_done_cycle", dc, lc + 1);
   endtask

   task automatic test_backpressure();
      int nw, nd, fv, frd, lc, dc;
      fill_pattern();
      run_a(1, 1'b0, nw, nd, fv, frd, lc, dc);
      check_count("bp_words", nw, 6);
      check_count("bp_done", nd, 1);
      check_count("bp_done_cycle", dc, lc + 1);
   endtask

   task automatic test_restart();
      int nw, nd, fv, frd, lc, dc;
      fill_pattern();
      run_a(0, 1'b1, nw, nd, fv, frd, lc, dc);
      check_count("restart_words", nw, 6);
      check_count("restart_done", nd, 1);
   endtask

   task automatic test_random();
      int nw, nd, fv, frd, lc, dc;
      for (int i = 0; i < 4; i++) begin
         fill_random();
         run_a(2, 1'b0, nw, nd, fv, frd, lc, dc);
         check_count("rand_words", nw, 6);
         check_count("rand_done", nd, 1);
`ifdef GSRAM_ARGMAX_EN
         check_count("rand_amax_pulses", n_amax, NR);
`endif
      end
   endtask

   task automatic test_abort();
      int hs_n = 0;
      int nw, nd, fv, frd, lc, dc;
      fill_pattern();
      @(negedge clk);
      start_a = 1'b1;
      res_a.out_ready = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc < 50 && hs_n < 3; cyc++) begin
         @(negedge clk);
         start_a = 1'b0;
         #1;
         if (res_a.out_valid) hs_n++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || res_a.out_valid !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL abort got busy=%b v=%b done=%b expected 0 0 0", busy_a, res_a.out_valid, done_a);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got done=%b busy=%b expected 0", done_a, busy_a);
         end
      end
      run_a(0, 1'b0, nw, nd, fv, frd, lc, dc);
      check_count("replay_words", nw, 6);
      check_count("replay_done", nd, 1);
   endtask

`ifdef GSRAM_ARGMAX_EN
   task automatic test_argmax();
      int nw, nd, fv, frd, lc, dc;
      fill_random();
      mem_a[0][0] = 16'h0100; mem_a[0][1] = 16'hFF00; mem_a[0][2] = 16'h0100;
      mem_a[1][0] = 16'h8000; mem_a[1][1] = 16'hFFFF; mem_a[1][2] = 16'h7FFF;
      run_a(1, 1'b0, nw, nd, fv, frd, lc, dc);
      check_count("amax_pulses", n_amax, 2);
      check_count("amax_row0", am_idx[0], 0);
      check_count("amax_row1", am_idx[1], 2);
   endtask
`endif

   task automatic test_single();
      logic [DATA_W-1:0] d0;
      int seen = 0;
      mem_b[0][0] = DATA_W'($urandom);
      res_b.out_ready = 1'b0;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 20 && !res_b.out_valid; i++) @(negedge clk);
      check_count("single_valid", int'(res_b.out_valid), 1);
      d0 = res_b.out_data;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (res_b.out_valid !== 1'b1 || res_b.out_data !== mem_b[0][0] ||
             res_b.out_data !== d0 || res_b.out_last !== 1'b1 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL single_hold got v=%b d=%h l=%b done=%b expected v=1 d=%h l=1 done=0",
                     res_b.out_valid, res_b.out_data, res_b.out_last, done_b, mem_b[0][0]);
         end
         @(negedge clk);
      end
      res_b.out_ready = 1'b1;
      @(negedge clk);
      res_b.out_ready = 1'b0;
      check_count("single_done", int'(done_b), 1);
      check_count("single_empty", int'(res_b.out_valid), 0);
      @(negedge clk);
      if (done_b) seen = 1;
      check_count("single_done_once", seen, 0);
   endtask

   initial begin
      rdata_a = '0;
      rdata_b = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_restart();
      test_random();
      test_abort();
`ifdef GSRAM_ARGMAX_EN
      test_argmax();
`endif
      test_single();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
